// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared state type and default dimensions for the GEMM stream host
package gemm_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int MATRIX_WIDTH  = 4;
  localparam int MATRIX_HEIGHT = 4;
  localparam int MATRIX_ADJUST = 4;

  localparam int A_ELEMS      = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int B_ELEMS      = MATRIX_ADJUST * MATRIX_WIDTH;
  localparam int C_ELEMS      = MATRIX_HEIGHT * MATRIX_ADJUST;
  localparam int RESULT_ELEMS = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int LOAD_WORDS   = 2 + A_ELEMS + B_ELEMS + C_ELEMS;

  typedef enum logic [2:0] {
    LD_SCALAR,
    LD_A,
    LD_B,
    LD_C,
    KICK,
    WAIT,
    DRAIN
  } gemm_host_state_t;

endpackage

// File: rtl/mat_stream_out.sv
// rtl/mat_stream_out.sv - result buffer drained row-major as a valid/ready word stream
module mat_stream_out #(
  parameter int DATA_WIDTH = 64,
  parameter int HEIGHT     = 4,
  parameter int WIDTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_capture,
  input  logic [DATA_WIDTH-1:0] i_matrix [HEIGHT][WIDTH],
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_done
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_buf [HEIGHT][WIDTH];
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic                  r_valid;
  logic                  w_at_end;
  logic                  w_col_end;
  logic                  w_fire;

  assign w_col_end = (r_col == CW'(WIDTH - 1));
  assign w_at_end  = w_col_end && (r_row == RW'(HEIGHT - 1));
  assign w_fire    = r_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < HEIGHT; i++) begin
        for (int j = 0; j < WIDTH; j++) begin
          r_buf[i][j] <= '0;
        end
      end
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_buf   <= i_matrix;
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (w_at_end) begin
        r_row   <= '0;
        r_col   <= '0;
        r_valid <= 1'b0;
      end else if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < HEIGHT; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (r_row == RW'(i) && r_col == CW'(j)) begin
          o_data = r_buf[i][j];
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_valid && w_at_end;
  assign o_done  = w_fire && w_at_end;

endmodule

// File: rtl/gemm_stream_host.sv
// rtl/gemm_stream_host.sv - loads alpha/beta/A/B/C from a word stream, kicks the engine, drains its result
module gemm_stream_host
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH    = gemm_pkg::DATA_WIDTH,
  parameter int MATRIX_WIDTH  = gemm_pkg::MATRIX_WIDTH,
  parameter int MATRIX_HEIGHT = gemm_pkg::MATRIX_HEIGHT,
  parameter int MATRIX_ADJUST = gemm_pkg::MATRIX_ADJUST
) (
  input  logic                         iclk,
  input  logic                         irst_n,
  input  logic                         ivalid,
  input  logic [DATA_WIDTH-1:0]        idata,
  output logic                         oready,
  output logic [DATA_WIDTH-1:0]        oalpha,
  output logic [DATA_WIDTH-1:0]        obeta,
  output logic signed [DATA_WIDTH-1:0] oa_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  output logic signed [DATA_WIDTH-1:0] ob_matrix [MATRIX_ADJUST][MATRIX_WIDTH],
  output logic signed [DATA_WIDTH-1:0] oc_matrix [MATRIX_HEIGHT][MATRIX_ADJUST],
  output logic                         ostart,
  input  logic                         idone,
  input  logic [DATA_WIDTH-1:0]        iresult_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  output logic                         ovalid,
  output logic [DATA_WIDTH-1:0]        odata,
  output logic                         olast,
  input  logic                         iready,
  output logic                         obusy
);

  localparam int MAX_HW  = (MATRIX_HEIGHT > MATRIX_WIDTH) ? MATRIX_HEIGHT : MATRIX_WIDTH;
  localparam int MAX_DIM = (MAX_HW > MATRIX_ADJUST) ? MAX_HW : MATRIX_ADJUST;
  localparam int CNT_W   = $clog2(((MAX_DIM > 2) ? MAX_DIM : 2) + 1);

  gemm_host_state_t r_state, w_next;

  logic [CNT_W-1:0]             r_row, r_col;
  logic [CNT_W-1:0]             w_rows, w_cols;
  logic                         w_accept, w_col_end, w_phase_end;
  logic                         w_capture, w_drain_done;
  logic [DATA_WIDTH-1:0]        r_alpha, r_beta;
  logic signed [DATA_WIDTH-1:0] r_a [MATRIX_HEIGHT][MATRIX_WIDTH];
  logic signed [DATA_WIDTH-1:0] r_b [MATRIX_ADJUST][MATRIX_WIDTH];
  logic signed [DATA_WIDTH-1:0] r_c [MATRIX_HEIGHT][MATRIX_ADJUST];

  // The scalar phase is a 1x2 "matrix": alpha at column 0, beta at column 1.
  always_comb begin
    w_rows = CNT_W'(1);
    w_cols = CNT_W'(2);
    case (r_state)
      LD_A: begin
        w_rows = CNT_W'(MATRIX_HEIGHT);
        w_cols = CNT_W'(MATRIX_WIDTH);
      end
      LD_B: begin
        w_rows = CNT_W'(MATRIX_ADJUST);
        w_cols = CNT_W'(MATRIX_WIDTH);
      end
      LD_C: begin
        w_rows = CNT_W'(MATRIX_HEIGHT);
        w_cols = CNT_W'(MATRIX_ADJUST);
      end
      default: ;
    endcase
  end

  assign w_accept    = ivalid && oready;
  assign w_col_end   = (r_col == w_cols - CNT_W'(1));
  assign w_phase_end = w_col_end && (r_row == w_rows - CNT_W'(1));
  assign w_capture   = (r_state == WAIT) && idone;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_state <= LD_SCALAR;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    oready = 1'b0;
    ostart = 1'b0;
    obusy  = 1'b0;
    case (r_state)
      LD_SCALAR: begin
        oready = 1'b1;
        if (w_accept && w_phase_end) w_next = LD_A;
      end
      LD_A: begin
        oready = 1'b1;
        if (w_accept && w_phase_end) w_next = LD_B;
      end
      LD_B: begin
        oready = 1'b1;
        if (w_accept && w_phase_end) w_next = LD_C;
      end
      LD_C: begin
        oready = 1'b1;
        if (w_accept && w_phase_end) w_next = KICK;
      end
      KICK: begin
        ostart = 1'b1;
        obusy  = 1'b1;
        w_next = WAIT;
      end
      WAIT: begin
        obusy = 1'b1;
        if (idone) w_next = DRAIN;
      end
      DRAIN: begin
        obusy = 1'b1;
        if (w_drain_done) w_next = LD_SCALAR;
      end
      default: w_next = LD_SCALAR;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_next != r_state) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_alpha <= '0;
      r_beta  <= '0;
      for (int i = 0; i < MATRIX_HEIGHT; i++) begin
        for (int j = 0; j < MATRIX_WIDTH; j++) r_a[i][j] <= '0;
        for (int j = 0; j < MATRIX_ADJUST; j++) r_c[i][j] <= '0;
      end
      for (int i = 0; i < MATRIX_ADJUST; i++) begin
        for (int j = 0; j < MATRIX_WIDTH; j++) r_b[i][j] <= '0;
      end
    end else if (w_accept) begin
      case (r_state)
        LD_SCALAR: begin
          if (r_col == '0) r_alpha <= idata;
          else             r_beta  <= idata;
        end
        LD_A: begin
          for (int i = 0; i < MATRIX_HEIGHT; i++)
            for (int j = 0; j < MATRIX_WIDTH; j++)
              if (r_row == CNT_W'(i) && r_col == CNT_W'(j)) r_a[i][j] <= idata;
        end
        LD_B: begin
          for (int i = 0; i < MATRIX_ADJUST; i++)
            for (int j = 0; j < MATRIX_WIDTH; j++)
              if (r_row == CNT_W'(i) && r_col == CNT_W'(j)) r_b[i][j] <= idata;
        end
        LD_C: begin
          for (int i = 0; i < MATRIX_HEIGHT; i++)
            for (int j = 0; j < MATRIX_ADJUST; j++)
              if (r_row == CNT_W'(i) && r_col == CNT_W'(j)) r_c[i][j] <= idata;
        end
        default: ;
      endcase
    end
  end

  assign oalpha    = r_alpha;
  assign obeta     = r_beta;
  assign oa_matrix = r_a;
  assign ob_matrix = r_b;
  assign oc_matrix = r_c;

  mat_stream_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .HEIGHT     (MATRIX_HEIGHT),
    .WIDTH      (MATRIX_WIDTH)
  ) u_out (
    .i_clk     (iclk),
    .i_rst_n   (irst_n),
    .i_capture (w_capture),
    .i_matrix  (iresult_matrix),
    .o_valid   (ovalid),
    .o_data    (odata),
    .o_last    (olast),
    .i_ready   (iready),
    .o_done    (w_drain_done)
  );

endmodule

// File: tb/tb_gemm_stream_host.sv
// tb/tb_gemm_stream_host.sv - directed self-checking bench for gemm_stream_host
module tb_gemm_stream_host;
  import gemm_pkg::*;

  logic               iclk = 1'b0;
  logic               irst_n = 1'b0;
  logic               ivalid;
  logic [63:0]        idata;
  logic               oready;
  logic [63:0]        oalpha, obeta;
  logic signed [63:0] oa_matrix [4][4];
  logic signed [63:0] ob_matrix [4][4];
  logic signed [63:0] oc_matrix [4][4];
  logic               ostart;
  logic               idone;
  logic [63:0]        iresult_matrix [4][4];
  logic               ovalid;
  logic [63:0]        odata;
  logic               olast;
  logic               iready;
  logic               obusy;

  int n_tests = 0;
  int n_fail  = 0;

  gemm_stream_host dut (
    .iclk           (iclk),
    .irst_n         (irst_n),
    .ivalid         (ivalid),
    .idata          (idata),
    .oready         (oready),
    .oalpha         (oalpha),
    .obeta          (obeta),
    .oa_matrix      (oa_matrix),
    .ob_matrix      (ob_matrix),
    .oc_matrix      (oc_matrix),
    .ostart         (ostart),
    .idone          (idone),
    .iresult_matrix (iresult_matrix),
    .ovalid         (ovalid),
    .odata          (odata),
    .olast          (olast),
    .iready         (iready),
    .obusy          (obusy)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_result(input int base);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        iresult_matrix[i][j] = 64'(base + 4 * i + j);
  endtask

  task automatic send(input logic [63:0] w);
    ivalid = 1'b1;
    idata  = w;
    @(negedge iclk);
    ivalid = 1'b0;
  endtask

  task automatic load_job(input logic [63:0] alpha, input logic [63:0] beta,
                          input logic [63:0] a_base, input logic [63:0] b_val,
                          input logic [63:0] c_val, input bit b_ident,
                          input bit gapped, input bit spurious);
    logic [63:0] w [LOAD_WORDS];
    w[0] = alpha;
    w[1] = beta;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w[2 + 4 * i + j]  = a_base + 64'(4 * i + j);
        w[18 + 4 * i + j] = b_ident ? ((i == j) ? 64'd1 : 64'd0) : b_val;
        w[34 + 4 * i + j] = c_val;
      end
    end
    for (int k = 0; k < LOAD_WORDS; k++) begin
      if (k == LOAD_WORDS - 1) chk("ostart_before_last", ostart, 1'b0);
      if (spurious && k == 5) begin
        set_result(999);
        idone = 1'b1;
      end
      send(w[k]);
      idone = 1'b0;
      if (gapped && k != LOAD_WORDS - 1) @(negedge iclk);
    end
    chk("ostart_after_last", ostart, 1'b1);
    chk("obusy_kick", obusy, 1'b1);
    chk("oready_kick", oready, 1'b0);
    if (spurious) idone = 1'b1;
    @(negedge iclk);
    idone = 1'b0;
    chk("ostart_one_cycle", ostart, 1'b0);
    chk("obusy_wait", obusy, 1'b1);
  endtask

  task automatic drain(input int base, input bit stall);
    int e = 0;
    int c = 0;
    while (e < RESULT_ELEMS && c < 64) begin
      chk("drain_valid", ovalid, 1'b1);
      chk("drain_data", odata, 64'(base + e));
      chk("drain_last", olast, (e == RESULT_ELEMS - 1));
      iready = stall ? (c % 2 == 0) : 1'b1;
      @(negedge iclk);
      if (iready) e++;
      c++;
    end
    iready = 1'b0;
    chk("drain_count", e, RESULT_ELEMS);
    chk("drain_end_valid", ovalid, 1'b0);
    chk("drain_end_ready", oready, 1'b1);
    chk("drain_end_busy", obusy, 1'b0);
  endtask

  initial begin
    ivalid = 1'b0;
    idata  = '0;
    idone  = 1'b0;
    iready = 1'b0;
    set_result(0);
    repeat (2) @(negedge iclk);
    chk("rst_oready", oready, 1'b1);
    chk("rst_ostart", ostart, 1'b0);
    chk("rst_ovalid", ovalid, 1'b0);
    chk("rst_olast", olast, 1'b0);
    chk("rst_obusy", obusy, 1'b0);
    chk("rst_alpha", oalpha, 64'd0);
    chk("rst_a33", oa_matrix[3][3], 64'd0);
    chk("rst_odata", odata, 64'd0);
    irst_n = 1'b1;
    @(negedge iclk);

    // Job 1: ungapped load with spurious done pulses in LD_A and KICK.
    load_job(64'd2, 64'd3, 64'd0, 64'd0, 64'd1, 1'b1, 1'b0, 1'b1);
    chk("j1_alpha", oalpha, 64'd2);
    chk("j1_beta", obeta, 64'd3);
    chk("j1_a32", oa_matrix[3][2], 64'd14);
    chk("j1_a01", oa_matrix[0][1], 64'd1);
    chk("j1_b11", ob_matrix[1][1], 64'd1);
    chk("j1_b12", ob_matrix[1][2], 64'd0);
    chk("j1_c23", oc_matrix[2][3], 64'd1);
    repeat (3) begin
      @(negedge iclk);
      chk("j1_wait_novalid", ovalid, 1'b0);
      chk("j1_wait_busy", obusy, 1'b1);
    end
    set_result(100);
    idone = 1'b1;
    @(negedge iclk);
    idone = 1'b0;
    drain(100, 1'b1);

    // Job 2: starts the cycle after the final handshake, no input gaps.
    load_job(64'h11, 64'h22, 64'd32, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("j2_alpha", oalpha, 64'h11);
    chk("j2_a32", oa_matrix[3][2], 64'd46);
    chk("j2_b20", ob_matrix[2][0], 64'd2);
    chk("j2_c33", oc_matrix[3][3], 64'hFFFF_FFFF_FFFF_FFFF);
    set_result(200);
    idone = 1'b1;
    @(negedge iclk);
    idone = 1'b0;
    drain(200, 1'b0);

    // Job 3: gapped load, then reset in the middle of the drain.
    load_job(64'd7, 64'd8, 64'h100, 64'd3, 64'd5, 1'b0, 1'b1, 1'b0);
    chk("j3_alpha", oalpha, 64'd7);
    chk("j3_beta", obeta, 64'd8);
    chk("j3_a32", oa_matrix[3][2], 64'h10E);
    chk("j3_b03", ob_matrix[0][3], 64'd3);
    chk("j3_c11", oc_matrix[1][1], 64'd5);
    set_result(300);
    idone = 1'b1;
    @(negedge iclk);
    idone = 1'b0;
    iready = 1'b1;
    repeat (5) @(negedge iclk);
    chk("j3_mid_data", odata, 64'd305);
    #2 irst_n = 1'b0;
    #1;
    chk("abort_ovalid", ovalid, 1'b0);
    chk("abort_ostart", ostart, 1'b0);
    chk("abort_obusy", obusy, 1'b0);
    chk("abort_oready", oready, 1'b1);
    chk("abort_alpha", oalpha, 64'd0);
    chk("abort_a32", oa_matrix[3][2], 64'd0);
    chk("abort_c11", oc_matrix[1][1], 64'd0);
    iready = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;
    @(negedge iclk);
    chk("post_rst_oready", oready, 1'b1);
    chk("post_rst_ovalid", ovalid, 1'b0);
    chk("post_rst_olast", olast, 1'b0);
    chk("post_rst_odata", odata, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
